// File: rtl/pipeline_hazard_controller.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | pipeline_hazard_controller: stall/flush/forwarding control, 5-stage pipe |
// | Optional perf counters: define HAZARD_PERF_COUNTERS_EN.   Rev 1.0        |
// +--------------------------------------------------------------------------+
module pipeline_hazard_controller #(
  parameter int LOAD_STALL_CYCLES = 1,
  parameter int COUNT_WIDTH       = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [4:0]             id_rs,
  input  logic [4:0]             id_rt,
  input  logic                   id_uses_rs,
  input  logic                   id_uses_rt,
  input  logic                   id_jump,
  input  logic [4:0]             ex_rs,
  input  logic [4:0]             ex_rt,
  input  logic                   ex_mem_read,
  input  logic                   ex_reg_write,
  input  logic [4:0]             ex_write_reg,
  input  logic [4:0]             me_write_reg,
  input  logic [4:0]             wb_write_reg,
  input  logic                   me_reg_write,
  input  logic                   wb_reg_write,
  input  logic                   me_mem_access,
  input  logic                   dmem_ready,
  input  logic                   branch_taken_me,
  output logic                   pc_write,
  output logic                   if_id_write,
  output logic                   id_ex_write,
  output logic                   ex_me_write,
  output logic                   me_wb_write,
  output logic                   if_id_flush,
  output logic                   id_ex_flush,
  output logic                   ex_me_flush,
  output logic [1:0]             fwd_a,
  output logic [1:0]             fwd_b,
  output logic [COUNT_WIDTH-1:0] stall_count,
  output logic [COUNT_WIDTH-1:0] flush_count
);

  typedef enum logic [1:0] {
    RUN        = 2'd0,
    LOAD_STALL = 2'd1,
    MEM_WAIT   = 2'd2
  } state_t;

  localparam logic [1:0] C_STALL_INIT = 2'(LOAD_STALL_CYCLES - 1);

  state_t     state_q, state_d, ret_q, ret_d, w_eff_state;
  logic [1:0] cnt_q, cnt_d;
  logic       w_mem_wait, w_load_use;

  assign w_mem_wait = me_mem_access & ~dmem_ready;
  assign w_load_use = ex_mem_read & ex_reg_write & (ex_write_reg != 5'd0) &
                      ((id_uses_rs & (id_rs == ex_write_reg)) |
                       (id_uses_rt & (id_rt == ex_write_reg)));

  // A released memory wait behaves as the state it interrupted, in the same cycle.
  assign w_eff_state = (state_q == MEM_WAIT) ? ret_q : state_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= RUN;
      ret_q   <= RUN;
      cnt_q   <= 2'd0;
    end else begin
      state_q <= state_d;
      ret_q   <= ret_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    pc_write    = 1'b1;
    if_id_write = 1'b1;
    id_ex_write = 1'b1;
    ex_me_write = 1'b1;
    me_wb_write = 1'b1;
    if_id_flush = 1'b0;
    id_ex_flush = 1'b0;
    ex_me_flush = 1'b0;
    state_d     = w_eff_state;
    ret_d       = ret_q;
    cnt_d       = cnt_q;
    if (reset) begin
      {pc_write, if_id_write, id_ex_write, ex_me_write, me_wb_write} = 5'b00000;
      {if_id_flush, id_ex_flush, ex_me_flush} = 3'b111;
      state_d = RUN;
      ret_d   = RUN;
      cnt_d   = 2'd0;
    end else if (w_mem_wait) begin
      {pc_write, if_id_write, id_ex_write, ex_me_write, me_wb_write} = 5'b00000;
      state_d = MEM_WAIT;
      if (state_q != MEM_WAIT) begin
        ret_d = state_q;
      end
    end else if (branch_taken_me) begin
      {if_id_flush, id_ex_flush, ex_me_flush} = 3'b111;
      state_d = RUN;
      cnt_d   = 2'd0;
    end else if (w_eff_state == LOAD_STALL) begin
      pc_write    = 1'b0;
      if_id_write = 1'b0;
      id_ex_flush = 1'b1;
      cnt_d       = 2'(cnt_q - 2'd1);
      state_d     = (cnt_q == 2'd1) ? RUN : LOAD_STALL;
    end else if (w_load_use) begin
      pc_write    = 1'b0;
      if_id_write = 1'b0;
      id_ex_flush = 1'b1;
      cnt_d       = C_STALL_INIT;
      state_d     = (LOAD_STALL_CYCLES == 1) ? RUN : LOAD_STALL;
    end else if (id_jump) begin
      if_id_flush = 1'b1;
    end
  end

  // ME result is newer than WB data, so it wins; $0 is never forwarded.
  always_comb begin
    fwd_a = 2'b00;
    fwd_b = 2'b00;
    if (!reset) begin
      if (me_reg_write && me_write_reg != 5'd0 && me_write_reg == ex_rs)      fwd_a = 2'b10;
      else if (wb_reg_write && wb_write_reg != 5'd0 && wb_write_reg == ex_rs) fwd_a = 2'b01;
      if (me_reg_write && me_write_reg != 5'd0 && me_write_reg == ex_rt)      fwd_b = 2'b10;
      else if (wb_reg_write && wb_write_reg != 5'd0 && wb_write_reg == ex_rt) fwd_b = 2'b01;
    end
  end

`ifdef HAZARD_PERF_COUNTERS_EN
  logic [COUNT_WIDTH-1:0] stall_count_q, flush_count_q;
  logic                   w_flush_evt;

  assign w_flush_evt = if_id_flush & ~reset;

  always_ff @(posedge clk) begin
    if (reset) begin
      stall_count_q <= '0;
      flush_count_q <= '0;
    end else begin
      if (!pc_write && stall_count_q != '1) stall_count_q <= stall_count_q + 1'b1;
      if (w_flush_evt && flush_count_q != '1) flush_count_q <= flush_count_q + 1'b1;
    end
  end

  assign stall_count = stall_count_q;
  assign flush_count = flush_count_q;
`else
  assign stall_count = '0;
  assign flush_count = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_pipeline_hazard_controller.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_pipeline_hazard_controller: vectors, corner sequences, random vs model|
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module tb_pipeline_hazard_controller;

  typedef struct packed {
    logic [4:0] id_rs, id_rt;
    logic       id_uses_rs, id_uses_rt, id_jump;
    logic [4:0] ex_rs, ex_rt;
    logic       ex_mem_read, ex_reg_write;
    logic [4:0] ex_write_reg, me_write_reg, wb_write_reg;
    logic       me_reg_write, wb_reg_write, me_mem_access, dmem_ready, branch_taken_me;
  } in_t;

  typedef struct {
    string       nm;
    in_t         in;
    logic [11:0] exp;
  } vec_t;

  logic clk = 1'b0;
  logic reset;
  in_t  in;
  int   tests = 0, fails = 0;
  int   left1 = 0, left3 = 0;
  int   sc1 = 0, fc1 = 0, sc3 = 0, fc3 = 0;
  int   b1 = 0, b3 = 0;

  always #5 clk = ~clk;

  logic [11:0] o1, o3;
  logic [15:0] stall1, flush1;
  logic [3:0]  stall3, flush3;

  pipeline_hazard_controller #(.LOAD_STALL_CYCLES(1), .COUNT_WIDTH(16)) dut1 (
    .clk(clk), .reset(reset),
    .id_rs(in.id_rs), .id_rt(in.id_rt), .id_uses_rs(in.id_uses_rs), .id_uses_rt(in.id_uses_rt),
    .id_jump(in.id_jump), .ex_rs(in.ex_rs), .ex_rt(in.ex_rt), .ex_mem_read(in.ex_mem_read),
    .ex_reg_write(in.ex_reg_write), .ex_write_reg(in.ex_write_reg), .me_write_reg(in.me_write_reg),
    .wb_write_reg(in.wb_write_reg), .me_reg_write(in.me_reg_write), .wb_reg_write(in.wb_reg_write),
    .me_mem_access(in.me_mem_access), .dmem_ready(in.dmem_ready), .branch_taken_me(in.branch_taken_me),
    .pc_write(o1[11]), .if_id_write(o1[10]), .id_ex_write(o1[9]), .ex_me_write(o1[8]),
    .me_wb_write(o1[7]), .if_id_flush(o1[6]), .id_ex_flush(o1[5]), .ex_me_flush(o1[4]),
    .fwd_a(o1[3:2]), .fwd_b(o1[1:0]), .stall_count(stall1), .flush_count(flush1));

  pipeline_hazard_controller #(.LOAD_STALL_CYCLES(3), .COUNT_WIDTH(4)) dut3 (
    .clk(clk), .reset(reset),
    .id_rs(in.id_rs), .id_rt(in.id_rt), .id_uses_rs(in.id_uses_rs), .id_uses_rt(in.id_uses_rt),
    .id_jump(in.id_jump), .ex_rs(in.ex_rs), .ex_rt(in.ex_rt), .ex_mem_read(in.ex_mem_read),
    .ex_reg_write(in.ex_reg_write), .ex_write_reg(in.ex_write_reg), .me_write_reg(in.me_write_reg),
    .wb_write_reg(in.wb_write_reg), .me_reg_write(in.me_reg_write), .wb_reg_write(in.wb_reg_write),
    .me_mem_access(in.me_mem_access), .dmem_ready(in.dmem_ready), .branch_taken_me(in.branch_taken_me),
    .pc_write(o3[11]), .if_id_write(o3[10]), .id_ex_write(o3[9]), .ex_me_write(o3[8]),
    .me_wb_write(o3[7]), .if_id_flush(o3[6]), .id_ex_flush(o3[5]), .ex_me_flush(o3[4]),
    .fwd_a(o3[3:2]), .fwd_b(o3[1:0]), .stall_count(stall3), .flush_count(flush3));

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [1:0] fwd(input in_t x, input logic [4:0] src);
    if (x.me_reg_write && x.me_write_reg != 0 && x.me_write_reg == src) return 2'b10;
    if (x.wb_reg_write && x.wb_write_reg != 0 && x.wb_write_reg == src) return 2'b01;
    return 2'b00;
  endfunction

  // Reference: "left" is the number of bubbles still owed by a load-use stall.
  function automatic logic [11:0] model(input in_t x, input logic rst, input int lsc,
                                        input int left_in, output int left_out,
                                        output logic st, output logic fl);
    logic [3:0] f;
    logic       haz;
    left_out = left_in;
    st = 1'b0;
    fl = 1'b0;
    if (rst) begin
      left_out = 0;
      return {5'b00000, 3'b111, 4'b0000};
    end
    f   = {fwd(x, x.ex_rs), fwd(x, x.ex_rt)};
    haz = x.ex_mem_read && x.ex_reg_write && x.ex_write_reg != 0 &&
          ((x.id_uses_rs && x.id_rs == x.ex_write_reg) || (x.id_uses_rt && x.id_rt == x.ex_write_reg));
    if (x.me_mem_access && !x.dmem_ready) begin
      st = 1'b1;
      return {5'b00000, 3'b000, f};
    end
    if (x.branch_taken_me) begin
      left_out = 0;
      fl = 1'b1;
      return {5'b11111, 3'b111, f};
    end
    if (left_in > 0 || haz) begin
      left_out = (left_in > 0) ? left_in - 1 : lsc - 1;
      st = 1'b1;
      return {5'b00111, 3'b010, f};
    end
    if (x.id_jump) begin
      fl = 1'b1;
      return {5'b11111, 3'b100, f};
    end
    return {5'b11111, 3'b000, f};
  endfunction

  function automatic int sat(input int v, input int mx);
    return (v >= mx) ? mx : v + 1;
  endfunction

  // Called just after a falling edge with inputs applied; returns at the next falling edge.
  task automatic run_cycle(input string nm);
    logic [11:0] e1, e3;
    int   l1, l3;
    logic s1, f1, s3, f3;
    #1;
    e1 = model(in, reset, 1, left1, l1, s1, f1);
    e3 = model(in, reset, 3, left3, l3, s3, f3);
    chk({nm, " ctl lsc1"}, {20'd0, o1}, {20'd0, e1});
    chk({nm, " ctl lsc3"}, {20'd0, o3}, {20'd0, e3});
    if (!reset) begin
`ifdef HAZARD_PERF_COUNTERS_EN
      chk({nm, " cnt lsc1"}, {stall1, flush1}, {sc1[15:0], fc1[15:0]});
      chk({nm, " cnt lsc3"}, {24'd0, stall3, flush3}, {24'd0, sc3[3:0], fc3[3:0]});
`else
      chk({nm, " cnt lsc1"}, {stall1, flush1}, 32'd0);
      chk({nm, " cnt lsc3"}, {24'd0, stall3, flush3}, 32'd0);
`endif
    end
    if (!o1[11]) b1++;
    if (!o3[11]) b3++;
    @(posedge clk);
    left1 = l1;
    left3 = l3;
    if (reset) begin
      sc1 = 0; fc1 = 0; sc3 = 0; fc3 = 0;
    end else begin
      if (s1) sc1 = sat(sc1, 65535);
      if (f1) fc1 = sat(fc1, 65535);
      if (s3) sc3 = sat(sc3, 15);
      if (f3) fc3 = sat(fc3, 15);
    end
    @(negedge clk);
  endtask

  task automatic cycles(input string nm, input in_t x, input int n);
    for (int i = 0; i < n; i++) begin
      in = x;
      run_cycle(nm);
    end
  endtask

  in_t  nop, hz, mw, br, bj;
  vec_t tbl[11];

  initial begin
    nop = '0;
    nop.dmem_ready = 1'b1;
    hz = nop;
    hz.ex_mem_read = 1'b1; hz.ex_reg_write = 1'b1; hz.ex_write_reg = 5'd8;
    hz.id_rs = 5'd8; hz.id_uses_rs = 1'b1;
    mw = nop;
    mw.me_mem_access = 1'b1; mw.dmem_ready = 1'b0;
    br = nop;
    br.branch_taken_me = 1'b1;
    bj = br;
    bj.id_jump = 1'b1;

    tbl[0].nm = "fwd_me_priority"; tbl[0].in = nop;
    tbl[0].in.me_reg_write = 1; tbl[0].in.wb_reg_write = 1;
    tbl[0].in.me_write_reg = 5; tbl[0].in.wb_write_reg = 5; tbl[0].in.ex_rs = 5;
    tbl[0].exp = {5'b11111, 3'b000, 2'b10, 2'b00};
    tbl[1].nm = "fwd_reg0"; tbl[1].in = nop;
    tbl[1].in.me_reg_write = 1; tbl[1].in.wb_reg_write = 1;
    tbl[1].exp = {5'b11111, 3'b000, 2'b00, 2'b00};
    tbl[2].nm = "fwd_me_a_wb_b"; tbl[2].in = nop;
    tbl[2].in.me_reg_write = 1; tbl[2].in.me_write_reg = 3; tbl[2].in.ex_rs = 3;
    tbl[2].in.wb_reg_write = 1; tbl[2].in.wb_write_reg = 7; tbl[2].in.ex_rt = 7;
    tbl[2].exp = {5'b11111, 3'b000, 2'b10, 2'b01};
    tbl[3].nm = "fwd_me_disabled"; tbl[3].in = nop;
    tbl[3].in.me_write_reg = 9; tbl[3].in.ex_rs = 9;
    tbl[3].in.wb_reg_write = 1; tbl[3].in.wb_write_reg = 9;
    tbl[3].exp = {5'b11111, 3'b000, 2'b01, 2'b00};
    tbl[4].nm = "load_use"; tbl[4].in = hz;
    tbl[4].exp = {5'b00111, 3'b010, 4'b0000};
    tbl[5].nm = "load_src_unused"; tbl[5].in = hz; tbl[5].in.id_uses_rs = 0;
    tbl[5].exp = {5'b11111, 3'b000, 4'b0000};
    tbl[6].nm = "load_to_r0"; tbl[6].in = hz;
    tbl[6].in.ex_write_reg = 0; tbl[6].in.id_rs = 0;
    tbl[6].exp = {5'b11111, 3'b000, 4'b0000};
    tbl[7].nm = "jump"; tbl[7].in = nop; tbl[7].in.id_jump = 1;
    tbl[7].exp = {5'b11111, 3'b100, 4'b0000};
    tbl[8].nm = "branch_and_jump"; tbl[8].in = bj;
    tbl[8].exp = {5'b11111, 3'b111, 4'b0000};
    tbl[9].nm = "mem_wait_over_branch"; tbl[9].in = mw; tbl[9].in.branch_taken_me = 1;
    tbl[9].exp = {5'b00000, 3'b000, 4'b0000};
    tbl[10].nm = "mem_ready"; tbl[10].in = nop; tbl[10].in.me_mem_access = 1;
    tbl[10].exp = {5'b11111, 3'b000, 4'b0000};

    reset = 1'b1;
    in = tbl[0].in;
    @(negedge clk);
    #1 chk("reset_outputs", {20'd0, o1}, {20'd0, 5'b00000, 3'b111, 4'b0000});
    run_cycle("reset");
    in = nop;
    run_cycle("reset2");
    reset = 1'b0;

    for (int i = 0; i < 11; i++) begin
      in = tbl[i].in;
      #1 chk({"vec ", tbl[i].nm}, {20'd0, o1}, {20'd0, tbl[i].exp});
      run_cycle(tbl[i].nm);
    end
    cycles("drain", nop, 4);

    b1 = 0; b3 = 0;
    cycles("lu_hazard", hz, 1);
    cycles("lu_after", nop, 5);
    chk("bubbles_lsc1", b1, 1);
    chk("bubbles_lsc3", b3, 3);

    b3 = 0;
    cycles("br_hazard", hz, 1);
    cycles("br_bubble2", nop, 1);
    cycles("br_flush", br, 1);
    cycles("br_after", nop, 3);
    chk("bubbles_branch_cancel", b3, 2);

    b1 = 0; b3 = 0;
    cycles("mw_hazard", hz, 1);
    cycles("mw_wait", mw, 4);
    cycles("mw_resume", nop, 4);
    chk("bubbles_memwait_lsc1", b1, 5);
    chk("bubbles_memwait_lsc3", b3, 7);

    cycles("br_jump", bj, 1);
    cycles("sat_wait", mw, 20);
    in = nop;
    #1;
`ifdef HAZARD_PERF_COUNTERS_EN
    chk("stall_count_saturated", {28'd0, stall3}, 32'd15);
`else
    chk("stall_count_absent", {28'd0, stall3}, 32'd0);
`endif
    run_cycle("sat_after");

    b3 = 0;
    cycles("rst_hazard", hz, 1);
    reset = 1'b1;
    cycles("rst_mid", nop, 1);
    reset = 1'b0;
    cycles("rst_after", nop, 3);
    chk("bubbles_reset_abandon", b3, 2);

    for (int n = 0; n < 3000; n++) begin
      in.id_rs           = 5'($urandom_range(0, 3));
      in.id_rt           = 5'($urandom_range(0, 3));
      in.id_uses_rs      = 1'($urandom % 2);
      in.id_uses_rt      = 1'($urandom % 2);
      in.id_jump         = ($urandom % 8) == 0;
      in.ex_rs           = 5'($urandom_range(0, 3));
      in.ex_rt           = 5'($urandom_range(0, 3));
      in.ex_mem_read     = ($urandom % 3) == 0;
      in.ex_reg_write    = ($urandom % 4) != 0;
      in.ex_write_reg    = 5'($urandom_range(0, 3));
      in.me_write_reg    = 5'($urandom_range(0, 3));
      in.wb_write_reg    = 5'($urandom_range(0, 3));
      in.me_reg_write    = 1'($urandom % 2);
      in.wb_reg_write    = 1'($urandom % 2);
      in.me_mem_access   = ($urandom % 4) == 0;
      in.dmem_ready      = ($urandom % 3) != 0;
      in.branch_taken_me = ($urandom % 12) == 0;
      reset              = ($urandom % 60) == 0;
      run_cycle("random");
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/pipeline_hazard_controller.md
PIPELINE_HAZARD_CONTROLLER -- requirements
Module: pipeline_hazard_controller

Interface
REQ-001 SHALL have parameter LOAD_STALL_CYCLES, default 1, range 1..3: bubble cycles inserted per load-use hazard.
REQ-002 SHALL have parameter COUNT_WIDTH, default 16: width of the performance counters.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 id_rs, id_rt  input  5 each  source registers of the instruction in ID.
REQ-006 id_uses_rs, id_uses_rt  input  1 each  the ID instruction reads rs / rt.
REQ-007 id_jump  input  1  the ID instruction is j, jal or jr.
REQ-008 ex_rs, ex_rt  input  5 each  source registers of the instruction in EX.
REQ-009 ex_mem_read, ex_reg_write  input  1 each  EX-stage control bits.
REQ-010 ex_write_reg, me_write_reg, wb_write_reg  input  5 each  destination registers in EX, ME and WB.
REQ-011 me_reg_write, wb_reg_write  input  1 each  ME and WB write enables.
REQ-012 me_mem_access  input  1  the ME instruction performs lw or sw.
REQ-013 dmem_ready  input  1  data memory access completes this cycle.
REQ-014 branch_taken_me  input  1  the branch in ME is taken (beq/bne resolved).
REQ-015 pc_write, if_id_write, id_ex_write, ex_me_write, me_wb_write  output  1 each  register load enables.
REQ-016 if_id_flush, id_ex_flush, ex_me_flush  output  1 each  load a bubble (all controls zero).
REQ-017 fwd_a, fwd_b  output  2 each  ALU operand source: 00 register file, 10 ME ALU result, 01 WB write data.
REQ-018 stall_count, flush_count  output  COUNT_WIDTH each  performance counters.

Function
REQ-019 The FSM SHALL have three states: RUN, LOAD_STALL, MEM_WAIT.
REQ-020 A load-use hazard SHALL be ex_mem_read & ex_reg_write & ex_write_reg!=0 & ((id_uses_rs & id_rs==ex_write_reg) | (id_uses_rt & id_rt==ex_write_reg)).
REQ-021 A memory wait SHALL be me_mem_access & !dmem_ready. In any state it SHALL drive all five write enables to 0 and all flushes to 0. The state SHALL go to or stay in MEM_WAIT. The counter SHALL hold. It has the highest priority.
REQ-022 On leaving MEM_WAIT, the FSM SHALL return to the state held before entry.
REQ-023 If branch_taken_me is set and there is no memory wait, the block SHALL drive if_id_flush=id_ex_flush=ex_me_flush=1 and all write enables to 1. It SHALL then go to RUN, cancelling any pending stall.
REQ-024 Else, if there is a load-use hazard in RUN, the block SHALL drive pc_write=if_id_write=0 and id_ex_flush=1. It SHALL enter LOAD_STALL with counter=LOAD_STALL_CYCLES-1, or stay in RUN when LOAD_STALL_CYCLES=1.
REQ-025 In LOAD_STALL, the block SHALL drive the same stall outputs and decrement the counter. It SHALL go to RUN in the cycle the counter is 0, so total bubbles equal LOAD_STALL_CYCLES.
REQ-026 Else, if id_jump is set, the block SHALL drive if_id_flush=1 and all write enables to 1 for one cycle.
REQ-027 Otherwise all write enables SHALL be 1 and all flushes 0.
REQ-028 fwd_a SHALL be 10 when me_reg_write & me_write_reg!=0 & me_write_reg==ex_rs; else 01 when the same holds for WB; else 00. fwd_b is identical, using ex_rt. ME has priority over WB. Register 0 is never forwarded.
REQ-029 Forwarding outputs SHALL be combinational and independent of FSM state.
REQ-030 All other outputs SHALL be combinational from the current state and inputs, with no added latency.

Reset
REQ-031 While reset=1, the block SHALL drive all write enables to 0, all flushes to 1 and fwd_a=fwd_b=00.
REQ-032 Reset SHALL set the state to RUN, the stall counter to 0 and both performance counters to 0.
REQ-033 Reset asserted mid-stall or mid-wait SHALL abandon that stall or wait with no residual bubble.

Configuration
REQ-034 With HAZARD_PERF_COUNTERS_EN defined, stall_count SHALL increment, saturating, in every cycle where pc_write=0 outside reset.
REQ-035 With HAZARD_PERF_COUNTERS_EN defined, flush_count SHALL increment, saturating, once per branch or jump flush.
REQ-036 Without HAZARD_PERF_COUNTERS_EN, both counter outputs SHALL be constant 0 and no counter registers are built.

Verification
REQ-037 LOAD_STALL_CYCLES=1; lw $8 in EX, add using $8 in ID -> one cycle of pc_write=0 and id_ex_flush=1, then normal flow.
REQ-038 LOAD_STALL_CYCLES=3; same hazard -> exactly 3 bubble cycles; branch_taken_me in the 2nd bubble -> 3-stage flush and RUN next cycle.
REQ-039 me_write_reg=wb_write_reg=ex_rs=5, both writing -> fwd_a=10; ex_rs=0 with writers to $0 -> fwd_a=00.
REQ-040 me_mem_access=1, dmem_ready=0 for 4 cycles during LOAD_STALL -> all enables 0 for 4 cycles, then the remaining stall cycles resume.
REQ-041 branch_taken_me and id_jump set in the same cycle -> 3-stage flush; flush_count +1 when HAZARD_PERF_COUNTERS_EN is defined.
REQ-042 COUNT_WIDTH=4 with a 20-cycle stall pattern -> stall_count saturates at 15.
